axi32_lite_master: RTL and testbench
====================================

# axi32_lite_master

Single-outstanding AXI4-Lite master that turns a simple valid/ready command port into one AXI4-Lite write or read transaction and returns the result on a response port. It sits directly upstream of the axi32 register slave: its m_axi_* ports connect 1:1 to that slave's s_axi_* ports. This lets on-chip logic (sequencers, test controllers) drive the register block's control and status registers without a processor. A cycle timeout guarantees the master never hangs on a dead slave.

## Interface
- datawidth, 32, AXI data width; must be 32.
- addrwidth, 8, AXI address width.
- timeout_cycles, 256, cycles allowed per transaction before abort; must be ≥ 4. The counter width is clog2(timeout_cycles+1).
- m_axi_clk_in  in  1  single clock; all logic is rising-edge.
- m_axi_reset_n_in  in  1  synchronous, active-low reset.
- cmd_valid_in / cmd_ready_out  in/out  1  command handshake.
- cmd_write_in  in  1  1 = write, 0 = read.
- cmd_addr_in  in  addrwidth  byte address.
- cmd_wdata_in  in  datawidth  write data.
- cmd_wstrb_in  in  datawidth/8  write strobes.
- rsp_valid_out / rsp_ready_in  out/in  1  response handshake.
- rsp_rdata_out  out  datawidth  read data; 0 for writes.
- rsp_resp_out  out  2  BRESP/RRESP as received, or 2'b10 on timeout.
- rsp_timeout_out  out  1  1 = transaction aborted by timeout.
- m_axi_awaddr_out, m_axi_awvalid_out, m_axi_awready_in: AXI write address channel (addrwidth / 1 / 1).
- m_axi_wdata_out, m_axi_wstrb_out, m_axi_wvalid_out, m_axi_wready_in: AXI write data channel.
- m_axi_bresp_in, m_axi_bvalid_in, m_axi_bready_out: AXI write response channel.
- m_axi_araddr_out, m_axi_arvalid_out, m_axi_arready_in: AXI read address channel.
- m_axi_rdata_in, m_axi_rresp_in, m_axi_rvalid_in, m_axi_rready_out: AXI read data channel.

## Operation
- States:
  - IDLE → WR_REQ if cmd_write_in, else → RD_REQ.
  - WR_REQ → WR_RESP.
  - WR_RESP → RSP.
  - RD_REQ → RD_DATA.
  - RD_DATA → RSP.
  - RSP → IDLE.
- cmd_ready_out = (state == IDLE). A command is accepted on cmd_valid_in && cmd_ready_out. At acceptance, addr, wdata, wstrb and the write flag are registered; later changes on the cmd_* inputs are ignored.
- WR_REQ:
  - awvalid and wvalid are both asserted; each drops independently on the cycle after its own handshake.
  - Leaves to WR_RESP once both AW and W have completed, in either order or in the same cycle.
- WR_RESP: bready = 1. On bvalid && bready, capture bresp and go to RSP.
- RD_REQ: arvalid = 1 until arready is seen, then go to RD_DATA.
- RD_DATA: rready = 1. On rvalid && rready, capture rdata and rresp and go to RSP.
- RSP:
  - rsp_valid_out = 1; all rsp_* outputs are held stable until rsp_ready_in.
  - Then go to IDLE.
- Timeout counter:
  - Clears on command accept and increments every cycle in WR_REQ, WR_RESP, RD_REQ and RD_DATA.
  - If it reaches timeout_cycles before the completing handshake, all AXI valid/ready outputs deassert on the next cycle and the state goes to RSP with resp 2'b10, rdata 0 and rsp_timeout_out = 1.
  - A handshake that occurs in the same cycle the count is reached wins; no timeout is reported.
- Dropping valid on timeout is a deliberate AXI violation, used for recovery only.
- Late B/R responses after a timeout are not consumed; they are a system-level error.
- Response values are passed through unchanged (OKAY/SLVERR/DECERR); the block does no error interpretation.

## Timing
- Reset values:
  - state = IDLE, cmd_ready_out = 1.
  - rsp_valid_out = 0, rsp_rdata_out = 0, rsp_resp_out = 0, rsp_timeout_out = 0.
  - All m_axi valid/ready outputs = 0; all m_axi address/data/strb outputs = 0.
  - Timeout counter = 0.
- Reset mid-transaction returns to IDLE in one cycle with the values above; the in-flight command is lost and no response is issued.
- All AXI and rsp outputs are registered or decoded from registered state; there is no combinational path from any input to any output except cmd_ready_out, which depends on state only.
- Minimum latency with a zero-wait slave (command accepted on edge T):
  - Write: AW and W handshake at T+1, B at T+2, rsp_valid at T+3.
  - Read: AR at T+1, R at T+2, rsp_valid at T+3.
- Back-to-back throughput: a new command can be accepted on the edge that completes the rsp handshake +1, i.e. one idle cycle in IDLE.
- Only one transaction is outstanding at a time; AW/W and AR are never active together.

## Test plan
- Write at addr 0x04, wdata 0x0000_0003, wstrb 0xF, slave ready always high: AW/W at T+1, B OKAY at T+2, rsp_valid at T+3 with resp 0, timeout 0. The slave's control_0/1 outputs both read back 1.
- Read at 0x08 with status_0 = 1 and status_1 = 0, slave rdata 0x0000_0001: rsp_rdata_out = 0x0000_0001, resp 0, at T+3.
- Write with awready delayed 3 cycles and wready immediate: wvalid drops after T+1, awvalid is held to T+4, B handshake follows, single response.
- Slave never asserts arready, timeout_cycles = 8: arvalid drops and rsp_valid rises with resp 2'b10, rdata 0, timeout 1; the next command is accepted normally.
- rsp_ready_in held low 5 cycles: rsp_* stays stable, cmd_ready_out stays 0; IDLE is entered one cycle after rsp_ready_in rises.
- Reset asserted in WR_RESP: the next edge gives IDLE, bready 0, rsp_valid 0, cmd_ready 1; no response is issued.

Source files
------------

// File: rtl/axi32_lite_master.sv
`default_nettype none
// ============================================================================
// Module      : axi32_lite_master
// Description : Single-outstanding AXI4-Lite master. Converts a valid/ready
//               command into one AXI4-Lite write or read and returns the
//               response on a valid/ready response port. A per-transaction
//               cycle timeout aborts transactions to a dead slave.
// Revision    : 1.0 - initial release
// ============================================================================
module axi32_lite_master #(
    parameter int DATAWIDTH      = 32,
    parameter int ADDRWIDTH      = 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                   m_axi_clk_in,
    input  logic                   m_axi_reset_n_in,
    // command port
    input  logic                   cmd_valid_in,
    output logic                   cmd_ready_out,
    input  logic                   cmd_write_in,
    input  logic [ADDRWIDTH-1:0]   cmd_addr_in,
    input  logic [DATAWIDTH-1:0]   cmd_wdata_in,
    input  logic [DATAWIDTH/8-1:0] cmd_wstrb_in,
    // response port
    output logic                   rsp_valid_out,
    input  logic                   rsp_ready_in,
    output logic [DATAWIDTH-1:0]   rsp_rdata_out,
    output logic [1:0]             rsp_resp_out,
    output logic                   rsp_timeout_out,
    // AXI write address channel
    output logic [ADDRWIDTH-1:0]   m_axi_awaddr_out,
    output logic                   m_axi_awvalid_out,
    input  logic                   m_axi_awready_in,
    // AXI write data channel
    output logic [DATAWIDTH-1:0]   m_axi_wdata_out,
    output logic [DATAWIDTH/8-1:0] m_axi_wstrb_out,
    output logic                   m_axi_wvalid_out,
    input  logic                   m_axi_wready_in,
    // AXI write response channel
    input  logic [1:0]             m_axi_bresp_in,
    input  logic                   m_axi_bvalid_in,
    output logic                   m_axi_bready_out,
    // AXI read address channel
    output logic [ADDRWIDTH-1:0]   m_axi_araddr_out,
    output logic                   m_axi_arvalid_out,
    input  logic                   m_axi_arready_in,
    // AXI read data channel
    input  logic [DATAWIDTH-1:0]   m_axi_rdata_in,
    input  logic [1:0]             m_axi_rresp_in,
    input  logic                   m_axi_rvalid_in,
    output logic                   m_axi_rready_out
);

    localparam int                 c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_TO    = c_CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_REQ  = 3'd1,
        S_WR_RESP = 3'd2,
        S_RD_REQ  = 3'd3,
        S_RD_DATA = 3'd4,
        S_RSP     = 3'd5
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic                   w_done;
    logic                   w_timeout;
    logic                   w_accept;
    logic                   w_active;
    logic                   w_cnt_hit;
    logic                   w_aw_ok;
    logic                   w_w_ok;

    logic [c_CNT_W-1:0]     r_cnt;
    logic                   r_awvalid;
    logic                   r_wvalid;
    logic [ADDRWIDTH-1:0]   r_awaddr;
    logic [ADDRWIDTH-1:0]   r_araddr;
    logic [DATAWIDTH-1:0]   r_wdata;
    logic [DATAWIDTH/8-1:0] r_wstrb;
    logic [DATAWIDTH-1:0]   r_rsp_rdata;
    logic [1:0]             r_rsp_resp;
    logic                   r_rsp_timeout;

    assign w_accept  = cmd_valid_in && (r_state == S_IDLE);
    assign w_active  = (r_state == S_WR_REQ) || (r_state == S_WR_RESP) ||
                       (r_state == S_RD_REQ) || (r_state == S_RD_DATA);
    assign w_cnt_hit = (r_cnt == c_TO);
    // A channel is finished once its valid has dropped or it handshakes now
    assign w_aw_ok   = !r_awvalid || m_axi_awready_in;
    assign w_w_ok    = !r_wvalid  || m_axi_wready_in;

    // State register
    always_ff @(posedge m_axi_clk_in) begin
        if (!m_axi_reset_n_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; a phase-completing handshake beats the timeout
    always_comb begin
        w_next = r_state;
        w_done = 1'b0;
        case (r_state)
            S_IDLE:    if (cmd_valid_in) w_next = cmd_write_in ? S_WR_REQ : S_RD_REQ;
            S_WR_REQ:  if (w_aw_ok && w_w_ok) begin w_next = S_WR_RESP; w_done = 1'b1; end
            S_WR_RESP: if (m_axi_bvalid_in)   begin w_next = S_RSP;     w_done = 1'b1; end
            S_RD_REQ:  if (m_axi_arready_in)  begin w_next = S_RD_DATA; w_done = 1'b1; end
            S_RD_DATA: if (m_axi_rvalid_in)   begin w_next = S_RSP;     w_done = 1'b1; end
            S_RSP:     if (rsp_ready_in)      w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
        w_timeout = w_active && w_cnt_hit && !w_done;
        if (w_timeout) begin
            w_next = S_RSP;
        end
    end

    // Command capture, AW/W valid tracking, timeout counter, response capture
    always_ff @(posedge m_axi_clk_in) begin
        if (!m_axi_reset_n_in) begin
            r_cnt         <= '0;
            r_awvalid     <= 1'b0;
            r_wvalid      <= 1'b0;
            r_awaddr      <= '0;
            r_araddr      <= '0;
            r_wdata       <= '0;
            r_wstrb       <= '0;
            r_rsp_rdata   <= '0;
            r_rsp_resp    <= 2'b00;
            r_rsp_timeout <= 1'b0;
        end else begin
            // counter saturates at the limit so it never wraps past it
            if (w_accept) begin
                r_cnt <= '0;
            end else if (w_active && !w_cnt_hit) begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end

            if (w_accept) begin
                if (cmd_write_in) begin
                    r_awaddr  <= cmd_addr_in;
                    r_wdata   <= cmd_wdata_in;
                    r_wstrb   <= cmd_wstrb_in;
                    r_awvalid <= 1'b1;
                    r_wvalid  <= 1'b1;
                end else begin
                    r_araddr  <= cmd_addr_in;
                end
            end else if (r_state == S_WR_REQ) begin
                if (m_axi_awready_in || w_timeout) r_awvalid <= 1'b0;
                if (m_axi_wready_in  || w_timeout) r_wvalid  <= 1'b0;
            end

            if (w_timeout) begin
                r_rsp_rdata   <= '0;
                r_rsp_resp    <= 2'b10;
                r_rsp_timeout <= 1'b1;
            end else if ((r_state == S_WR_RESP) && m_axi_bvalid_in) begin
                r_rsp_rdata   <= '0;
                r_rsp_resp    <= m_axi_bresp_in;
                r_rsp_timeout <= 1'b0;
            end else if ((r_state == S_RD_DATA) && m_axi_rvalid_in) begin
                r_rsp_rdata   <= m_axi_rdata_in;
                r_rsp_resp    <= m_axi_rresp_in;
                r_rsp_timeout <= 1'b0;
            end
        end
    end

    assign cmd_ready_out     = (r_state == S_IDLE);
    assign rsp_valid_out     = (r_state == S_RSP);
    assign rsp_rdata_out     = r_rsp_rdata;
    assign rsp_resp_out      = r_rsp_resp;
    assign rsp_timeout_out   = r_rsp_timeout;
    assign m_axi_awaddr_out  = r_awaddr;
    assign m_axi_awvalid_out = r_awvalid;
    assign m_axi_wdata_out   = r_wdata;
    assign m_axi_wstrb_out   = r_wstrb;
    assign m_axi_wvalid_out  = r_wvalid;
    assign m_axi_bready_out  = (r_state == S_WR_RESP);
    assign m_axi_araddr_out  = r_araddr;
    assign m_axi_arvalid_out = (r_state == S_RD_REQ);
    assign m_axi_rready_out  = (r_state == S_RD_DATA);

endmodule
`default_nettype wire

// File: tb/tb_axi32_lite_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi32_lite_master
// Description : Self-checking bench for axi32_lite_master with a delay-
//               programmable slave and a transaction-level timing model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi32_lite_master;

    localparam int c_TO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [7:0]  awaddr, araddr;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    axi32_lite_master #(.DATAWIDTH(32), .ADDRWIDTH(8), .TIMEOUT_CYCLES(c_TO)) dut (
        .m_axi_clk_in(clk), .m_axi_reset_n_in(rst_n),
        .cmd_valid_in(cmd_valid), .cmd_ready_out(cmd_ready), .cmd_write_in(cmd_write),
        .cmd_addr_in(cmd_addr), .cmd_wdata_in(cmd_wdata), .cmd_wstrb_in(cmd_wstrb),
        .rsp_valid_out(rsp_valid), .rsp_ready_in(rsp_ready), .rsp_rdata_out(rsp_rdata),
        .rsp_resp_out(rsp_resp), .rsp_timeout_out(rsp_timeout),
        .m_axi_awaddr_out(awaddr), .m_axi_awvalid_out(awvalid), .m_axi_awready_in(awready),
        .m_axi_wdata_out(wdata), .m_axi_wstrb_out(wstrb), .m_axi_wvalid_out(wvalid),
        .m_axi_wready_in(wready), .m_axi_bresp_in(bresp), .m_axi_bvalid_in(bvalid),
        .m_axi_bready_out(bready), .m_axi_araddr_out(araddr), .m_axi_arvalid_out(arvalid),
        .m_axi_arready_in(arready), .m_axi_rdata_in(rdata), .m_axi_rresp_in(rresp),
        .m_axi_rvalid_in(rvalid), .m_axi_rready_out(rready)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // slave programming and bookkeeping
    int          s_da, s_dw, s_db;
    int          s_aw_cnt, s_w_cnt, s_ar_cnt, s_b_cnt, s_r_cnt;
    logic [7:0]  got_awaddr, got_araddr;
    logic [31:0] got_wdata;
    logic [3:0]  got_wstrb;
    logic        tr_aw [0:127];
    logic        tr_w  [0:127];
    logic        tr_ar [0:127];

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wd;
        logic [3:0]  ws;
        int          d1, d2, d3;
        logic [1:0]  sresp;
        logic [31:0] srd;
        int          exp_lat;
        logic [31:0] exp_rd;
        logic [1:0]  exp_rs;
        logic        exp_to;
    } vec_t;

    vec_t vecs [0:10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Slave reacts to DUT outputs of the current cycle; ready/valid rises
    // once the master has been waiting longer than the programmed delay.
    task automatic slave_step();
        if (awvalid) begin s_aw_cnt++; awready = (s_aw_cnt > s_da); end
        else begin s_aw_cnt = 0; awready = 1'b0; end
        if (wvalid) begin s_w_cnt++; wready = (s_w_cnt > s_dw); end
        else begin s_w_cnt = 0; wready = 1'b0; end
        if (arvalid) begin s_ar_cnt++; arready = (s_ar_cnt > s_da); end
        else begin s_ar_cnt = 0; arready = 1'b0; end
        if (bready) begin s_b_cnt++; bvalid = (s_b_cnt > s_db); end
        else begin s_b_cnt = 0; bvalid = 1'b0; end
        if (rready) begin s_r_cnt++; rvalid = (s_r_cnt > s_db); end
        else begin s_r_cnt = 0; rvalid = 1'b0; end
        if (awvalid && awready) got_awaddr = awaddr;
        if (wvalid && wready) begin got_wdata = wdata; got_wstrb = wstrb; end
        if (arvalid && arready) got_araddr = araddr;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        slave_step();
    endtask

    // Transaction-level timing: a transaction is two phases ending on cycles
    // e1 and e2 after acceptance. Once the cycle budget is spent, any cycle
    // that does not end the current phase aborts the transaction.
    function automatic void model(input logic wr, input int d1, input int d2, input int d3,
                                  input logic [1:0] sresp, input logic [31:0] srd,
                                  output int lat, output logic [31:0] rd,
                                  output logic [1:0] rs, output logic to);
        int e1, e2, first2, lim;
        lim    = c_TO + 1;
        e1     = (wr ? ((d1 > d2) ? d1 : d2) : d1) + 1;
        e2     = e1 + d3 + 1;
        first2 = (e1 + 1 > lim) ? e1 + 1 : lim;
        if (e1 > lim) begin
            lat = lim + 1; rd = 32'h0; rs = 2'b10; to = 1'b1;
        end else if (e2 > first2) begin
            lat = first2 + 1; rd = 32'h0; rs = 2'b10; to = 1'b1;
        end else begin
            lat = e2 + 1; rd = wr ? 32'h0 : srd; rs = sresp; to = 1'b0;
        end
    endfunction

    task automatic do_txn(input logic wr, input logic [7:0] a, input logic [31:0] wd,
                          input logic [3:0] ws, input int d1, input int d2, input int d3,
                          input logic [1:0] sresp, input logic [31:0] srd, input int hold,
                          output int lat, output logic [31:0] rd,
                          output logic [1:0] rs, output logic to);
        int n;
        s_da = d1; s_dw = d2; s_db = d3;
        bresp = sresp; rresp = sresp; rdata = srd;
        got_awaddr = 8'h0; got_araddr = 8'h0; got_wdata = 32'h0; got_wstrb = 4'h0;
        rsp_ready = (hold == 0);
        n = 0;
        while (!cmd_ready && n < 50) begin tick(); n++; end
        check("cmd_ready_before_txn", cmd_ready, 1'b1);
        cmd_write = wr; cmd_addr = a; cmd_wdata = wd; cmd_wstrb = ws; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        cmd_addr = 8'($urandom); cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
        cmd_write = 1'($urandom);
        lat = 1;
        tr_aw[1] = awvalid; tr_w[1] = wvalid; tr_ar[1] = arvalid;
        while (!rsp_valid && lat < 100) begin
            tick(); lat++;
            tr_aw[lat] = awvalid; tr_w[lat] = wvalid; tr_ar[lat] = arvalid;
        end
        rd = rsp_rdata; rs = rsp_resp; to = rsp_timeout;
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_rsp_valid", rsp_valid, 1'b1);
            check("hold_rsp_fields", {rsp_rdata, rsp_resp, rsp_timeout}, {rd, rs, to});
            check("hold_cmd_ready", cmd_ready, 1'b0);
        end
        rsp_ready = 1'b1;
        tick();
        check("idle_after_rsp", cmd_ready, 1'b1);
    endtask

    task automatic run_and_check(input string tag, input vec_t v);
        int lat; logic [31:0] rd; logic [1:0] rs; logic to;
        do_txn(v.wr, v.addr, v.wd, v.ws, v.d1, v.d2, v.d3, v.sresp, v.srd, 0, lat, rd, rs, to);
        check({tag, "_lat"}, lat, v.exp_lat);
        check({tag, "_rdata"}, rd, v.exp_rd);
        check({tag, "_resp"}, rs, v.exp_rs);
        check({tag, "_timeout"}, to, v.exp_to);
        if (!v.exp_to && v.wr) begin
            check({tag, "_awaddr"}, got_awaddr, v.addr);
            check({tag, "_wdata"}, {got_wdata, got_wstrb}, {v.wd, v.ws});
        end else if (!v.exp_to) begin
            check({tag, "_araddr"}, got_araddr, v.addr);
        end
    endtask

    initial begin
        int lat; logic [31:0] rd; logic [1:0] rs; logic to;
        vec_t v;

        // wr addr wdata wstrb d1 d2 d3 sresp srd | lat rdata resp timeout
        vecs[0]  = '{1'b1, 8'h04, 32'h3,        4'hF, 0,  0, 0, 2'b00, 32'h0,        3,  32'h0,        2'b00, 1'b0};
        vecs[1]  = '{1'b0, 8'h08, 32'h0,        4'h0, 0,  0, 0, 2'b00, 32'h1,        3,  32'h1,        2'b00, 1'b0};
        vecs[2]  = '{1'b1, 8'h10, 32'hA5A5_0001, 4'h3, 3, 0, 0, 2'b00, 32'h0,        6,  32'h0,        2'b00, 1'b0};
        vecs[3]  = '{1'b0, 8'h0C, 32'h0,        4'h0, 99, 0, 0, 2'b00, 32'h1234,     10, 32'h0,        2'b10, 1'b1};
        vecs[4]  = '{1'b1, 8'h14, 32'h5555_AAAA, 4'h8, 1, 2, 1, 2'b10, 32'h0,        6,  32'h0,        2'b10, 1'b0};
        vecs[5]  = '{1'b0, 8'h18, 32'h0,        4'h0, 2,  0, 2, 2'b11, 32'hDEAD_BEEF, 7, 32'hDEAD_BEEF, 2'b11, 1'b0};
        vecs[6]  = '{1'b0, 8'h1C, 32'h0,        4'h0, 8,  0, 0, 2'b01, 32'h0BAD_F00D, 11, 32'h0BAD_F00D, 2'b01, 1'b0};
        vecs[7]  = '{1'b0, 8'h20, 32'h0,        4'h0, 9,  0, 0, 2'b00, 32'h7777,     10, 32'h0,        2'b10, 1'b1};
        vecs[8]  = '{1'b1, 8'h24, 32'h1,        4'h1, 2,  5, 3, 2'b00, 32'h0,        10, 32'h0,        2'b10, 1'b1};
        vecs[9]  = '{1'b0, 8'h28, 32'h0,        4'h0, 0,  0, 7, 2'b00, 32'hCAFE_0001, 10, 32'hCAFE_0001, 2'b00, 1'b0};
        vecs[10] = '{1'b0, 8'h2C, 32'h0,        4'h0, 0,  0, 8, 2'b00, 32'hCAFE_0002, 10, 32'h0,        2'b10, 1'b1};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h0;
        cmd_wdata = 32'h0; cmd_wstrb = 4'h0; rsp_ready = 1'b1;
        awready = 1'b0; wready = 1'b0; arready = 1'b0; bvalid = 1'b0; rvalid = 1'b0;
        bresp = 2'b00; rresp = 2'b00; rdata = 32'h0;
        s_da = 0; s_dw = 0; s_db = 0;
        s_aw_cnt = 0; s_w_cnt = 0; s_ar_cnt = 0; s_b_cnt = 0; s_r_cnt = 0;
        repeat (3) tick();

        // reset state
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_rsp", {rsp_valid, rsp_rdata, rsp_resp, rsp_timeout}, 36'h0);
        check("rst_axi_ctl", {awvalid, wvalid, bready, arvalid, rready}, 5'b0);
        check("rst_axi_data", {awaddr, wdata, wstrb, araddr}, 52'h0);
        rst_n = 1'b1;
        tick();

        // directed table
        for (int i = 0; i <= 10; i++) run_and_check($sformatf("vec%0d", i), vecs[i]);

        // awready late by 3, wready immediate: W drops after cycle 1, AW held to cycle 4
        do_txn(1'b1, 8'h30, 32'h99, 4'hF, 3, 0, 0, 2'b00, 32'h0, 0, lat, rd, rs, to);
        check("aw_late_trace", {tr_aw[1], tr_aw[4], tr_aw[5], tr_w[1], tr_w[2]}, 5'b11010);
        check("aw_late_lat", lat, 6);

        // arready never: arvalid high through cycle 9, low at cycle 10
        do_txn(1'b0, 8'h34, 32'h0, 4'h0, 99, 0, 0, 2'b00, 32'h0, 0, lat, rd, rs, to);
        check("ar_to_trace", {tr_ar[1], tr_ar[9], tr_ar[10]}, 3'b110);
        check("ar_to_rsp", {rs, to, rd}, {2'b10, 1'b1, 32'h0});
        // next command after a timeout is accepted normally
        do_txn(1'b0, 8'h38, 32'h0, 4'h0, 0, 0, 0, 2'b00, 32'h4242, 0, lat, rd, rs, to);
        check("after_to_read", {lat, rd, rs, to}, {32'd3, 32'h4242, 2'b00, 1'b0});

        // rsp_ready held low for 5 cycles
        do_txn(1'b0, 8'h3C, 32'h0, 4'h0, 1, 0, 1, 2'b01, 32'h1357_9BDF, 5, lat, rd, rs, to);
        check("hold_vals", {lat, rd, rs, to}, {32'd5, 32'h1357_9BDF, 2'b01, 1'b0});

        // reset while waiting for B
        s_da = 0; s_dw = 0; s_db = 99; rsp_ready = 1'b1;
        cmd_write = 1'b1; cmd_addr = 8'h40; cmd_wdata = 32'h1; cmd_wstrb = 4'hF; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        check("wr_resp_bready", bready, 1'b1);
        rst_n = 1'b0;
        tick();
        check("rst_mid_ctl", {bready, rsp_valid, cmd_ready, awvalid, wvalid}, 5'b00100);
        rst_n = 1'b1;
        repeat (4) tick();
        check("rst_mid_no_rsp", {rsp_valid, cmd_ready}, 2'b01);

        // randomized transactions against the model
        for (int k = 0; k < 40; k++) begin
            v.wr = 1'($urandom); v.addr = 8'($urandom); v.wd = $urandom; v.ws = 4'($urandom);
            v.d1 = $urandom_range(0, 6); v.d2 = $urandom_range(0, 6); v.d3 = $urandom_range(0, 6);
            if ($urandom_range(0, 7) == 0) v.d1 = 12;
            v.sresp = 2'($urandom); v.srd = $urandom;
            model(v.wr, v.d1, v.d2, v.d3, v.sresp, v.srd, v.exp_lat, v.exp_rd, v.exp_rs, v.exp_to);
            run_and_check($sformatf("rnd%0d", k), v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
